// File: rtl/wb_regfile_pkg.sv
// Widths and constants shared by the pipeline stages that touch the
// integer register file.
package wb_regfile_pkg;
   localparam int               REG_ADDR_W = 5;
   localparam int               XLEN       = 32;
   localparam logic [4:0]       REG_ZERO   = 5'd0;
   localparam logic [XLEN-1:0]  ZERO_WORD  = 32'h0;
endpackage

// File: rtl/wb_regfile_sb_counter.sv
// Saturating pending-writer counter for one architectural register.
// dec_a is the writeback decrement, dec_b the squash decrement.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_a_i,
   input  logic             dec_b_i,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o,
   output logic             unf_o
);
   localparam int SW = CNT_W + 2;

   logic [CNT_W-1:0] count_q, count_d;
   logic [SW-1:0]    up_w, ndec_w, net_w, max_w;

   assign max_w  = {2'b00, {CNT_W{1'b1}}};
   assign up_w   = {2'b00, count_q} + {{(SW-1){1'b0}}, inc_i};
   assign ndec_w = {{(SW-1){1'b0}}, dec_a_i} + {{(SW-1){1'b0}}, dec_b_i};
   assign net_w  = up_w - ndec_w;

   // A lone writeback with nothing pending is an ordinary write that never
   // used the scoreboard; only a squash or a second decrement is an error.
   always_comb begin
      count_d = net_w[CNT_W-1:0];
      ovf_o   = 1'b0;
      unf_o   = 1'b0;
      if (ndec_w > up_w) begin
         count_d = '0;
         unf_o   = dec_b_i;
      end else if (net_w > max_w) begin
         count_d = max_w[CNT_W-1:0];
         ovf_o   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/wb_regfile.sv
// Integer register file x0..x31 with writeback bypass and a per-register
// pending-writer scoreboard used by ID for RAW stalls.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_reg_wdata_i,
   input  logic [4:0]  wb_reg_waddr_i,
   input  logic        wb_reg_we_i,
   input  logic        id_issue_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_rd_we_i,
   input  logic        kill_i,
   input  logic [4:0]  kill_rd_i,
   input  logic [4:0]  id_rs1_raddr_i,
   input  logic [4:0]  id_rs2_raddr_i,
   output logic [31:0] regs_rs1_rdata_o,
   output logic [31:0] regs_rs2_rdata_o,
   output logic        regs_rs1_busy_o,
   output logic        regs_rs2_busy_o,
   output logic        sb_err_o
);
   logic [XLEN-1:0]  regs_q [1:31];
   logic [CNT_W-1:0] cnt_w  [32];
   logic [31:0]      ovf_w, unf_w;
   logic             wb_hit_w;
   logic             err_q, err_d;
   logic [1:0]       ndec1_w, ndec2_w;

   assign wb_hit_w = wb_reg_we_i && (wb_reg_waddr_i != REG_ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 1; r < 32; r++) regs_q[r] <= ZERO_WORD;
      end else if (wb_hit_w) begin
         regs_q[wb_reg_waddr_i] <= wb_reg_wdata_i;
      end
   end

   assign regs_rs1_rdata_o = (id_rs1_raddr_i == REG_ZERO) ? ZERO_WORD :
                             (wb_hit_w && wb_reg_waddr_i == id_rs1_raddr_i) ? wb_reg_wdata_i :
                             regs_q[id_rs1_raddr_i];
   assign regs_rs2_rdata_o = (id_rs2_raddr_i == REG_ZERO) ? ZERO_WORD :
                             (wb_hit_w && wb_reg_waddr_i == id_rs2_raddr_i) ? wb_reg_wdata_i :
                             regs_q[id_rs2_raddr_i];

   assign cnt_w[0] = '0;
   assign ovf_w[0] = 1'b0;
   assign unf_w[0] = 1'b0;

   for (genvar r = 1; r < 32; r++) begin : g_sb
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc_i   (id_issue_i && id_rd_we_i && (id_rd_i == 5'(r))),
         .dec_a_i (wb_reg_we_i && (wb_reg_waddr_i == 5'(r))),
         .dec_b_i (kill_i && (kill_rd_i == 5'(r))),
         .count_o (cnt_w[r]),
         .ovf_o   (ovf_w[r]),
         .unf_o   (unf_w[r])
      );
   end

   // Busy looks at the count net of this cycle's retirements only, so a
   // writer leaving WB now is already covered by the bypass.
   assign ndec1_w = {1'b0, wb_reg_we_i && (wb_reg_waddr_i == id_rs1_raddr_i)}
                  + {1'b0, kill_i && (kill_rd_i == id_rs1_raddr_i)};
   assign ndec2_w = {1'b0, wb_reg_we_i && (wb_reg_waddr_i == id_rs2_raddr_i)}
                  + {1'b0, kill_i && (kill_rd_i == id_rs2_raddr_i)};

   assign regs_rs1_busy_o = (id_rs1_raddr_i != REG_ZERO) &&
                            ({2'b00, cnt_w[id_rs1_raddr_i]} > {{CNT_W{1'b0}}, ndec1_w});
   assign regs_rs2_busy_o = (id_rs2_raddr_i != REG_ZERO) &&
                            ({2'b00, cnt_w[id_rs2_raddr_i]} > {{CNT_W{1'b0}}, ndec2_w});

   assign err_d = err_q | (|ovf_w) | (|unf_w);

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign sb_err_o = err_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomised and directed bench for wb_regfile against a behavioural model
// of the register contents and pending-writer counts.
module tb_wb_regfile;
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wdata = '0;
   logic [4:0]  waddr = '0;
   logic        we = 1'b0;
   logic        issue = 1'b0;
   logic [4:0]  rd = '0;
   logic        rd_we = 1'b0;
   logic        kill = 1'b0;
   logic [4:0]  kill_rd = '0;
   logic [4:0]  rs1 = '0, rs2 = '0;
   logic [31:0] rdata1, rdata2;
   logic        busy1, busy2, sb_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_regs [32];
   int          m_cnt  [32];
   logic        m_err;

   wb_regfile #(.CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .wb_reg_wdata_i   (wdata),
      .wb_reg_waddr_i   (waddr),
      .wb_reg_we_i      (we),
      .id_issue_i       (issue),
      .id_rd_i          (rd),
      .id_rd_we_i       (rd_we),
      .kill_i           (kill),
      .kill_rd_i        (kill_rd),
      .id_rs1_raddr_i   (rs1),
      .id_rs2_raddr_i   (rs2),
      .regs_rs1_rdata_o (rdata1),
      .regs_rs2_rdata_o (rdata2),
      .regs_rs1_busy_o  (busy1),
      .regs_rs2_busy_o  (busy2),
      .sb_err_o         (sb_err)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (we && waddr == a) return wdata;
      return m_regs[a];
   endfunction

   function automatic int m_ndec(input logic [4:0] a);
      return ((we && waddr == a) ? 1 : 0) + ((kill && kill_rd == a) ? 1 : 0);
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      return (m_cnt[a] - m_ndec(a)) > 0;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic m_update();
      int n;
      if (rst) begin
         m_reset();
      end else begin
         for (int r = 1; r < 32; r++) begin
            n = m_cnt[r] + ((issue && rd_we && rd == r) ? 1 : 0) - m_ndec(5'(r));
            if (n < 0) begin
               if ((kill && kill_rd == r) || m_ndec(5'(r)) == 2) m_err = 1'b1;
               n = 0;
            end else if (n > MAXC) begin
               m_err = 1'b1;
               n = MAXC;
            end
            m_cnt[r] = n;
         end
         if (we && waddr != 0) m_regs[waddr] = wdata;
      end
   endtask

   // Model comparison on every cycle, away from the clock edge.
   task automatic settle();
      @(negedge clk);
      cmp("rdata1", rdata1, m_read(rs1));
      cmp("rdata2", rdata2, m_read(rs2));
      cmp("busy1", {31'b0, busy1}, {31'b0, m_busy(rs1)});
      cmp("busy2", {31'b0, busy2}, {31'b0, m_busy(rs2)});
      cmp("sb_err", {31'b0, sb_err}, {31'b0, m_err});
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic idle();
      we = 0; issue = 0; rd_we = 0; kill = 0; rst = 0;
   endtask

   task automatic drv_wb(input logic [4:0] a, input logic [31:0] d);
      we = 1; waddr = a; wdata = d;
   endtask

   task automatic drv_issue(input logic [4:0] a);
      issue = 1; rd_we = 1; rd = a;
   endtask

   initial begin
      m_reset();
      tick();
      idle();

      // reset state on every address
      for (int a = 0; a < 32; a++) begin
         rs1 = 5'(a); rs2 = 5'(31 - a);
         settle();
         cmp("rst_rd1", rdata1, 32'h0);
         cmp("rst_rd2", rdata2, 32'h0);
         cmp("rst_busy", {30'b0, busy1, busy2}, 32'h0);
         cmp("rst_err", {31'b0, sb_err}, 32'h0);
         tick();
      end

      // bypass and x0
      drv_wb(5, 32'hDEADBEEF); rs1 = 5;
      settle(); cmp("x5_bypass", rdata1, 32'hDEADBEEF); tick();
      idle(); settle(); cmp("x5_stored", rdata1, 32'hDEADBEEF); tick();
      drv_wb(0, 32'h1234); rs1 = 0;
      settle(); cmp("x0_bypass", rdata1, 32'h0); tick();
      idle(); settle(); cmp("x0_stored", rdata1, 32'h0); tick();

      // two in-flight writers on x7
      rs1 = 7; drv_issue(7);
      settle(); cmp("x7_no_sameclk_busy", {31'b0, busy1}, 32'h0); tick();
      settle(); tick();
      idle(); settle(); cmp("x7_busy2", {31'b0, busy1}, 32'h1); tick();
      drv_wb(7, 32'h1); settle(); cmp("x7_busy_after1", {31'b0, busy1}, 32'h1); tick();
      drv_wb(7, 32'h2); settle();
      cmp("x7_free", {31'b0, busy1}, 32'h0);
      cmp("x7_data", rdata1, 32'h2); tick();
      idle(); settle(); cmp("x7_free_next", {31'b0, busy1}, 32'h0); tick();

      // issue and writeback of x9 in the same cycle
      rs1 = 9; rs2 = 9; drv_issue(9); settle(); tick();
      drv_wb(9, 32'h99); settle(); tick();
      idle(); settle(); cmp("x9_still_busy", {31'b0, busy1}, 32'h1); tick();
      kill = 1; kill_rd = 9; settle(); cmp("x9_kill_free", {31'b0, busy2}, 32'h0); tick();
      idle(); settle();
      cmp("x9_after_kill", {31'b0, busy2}, 32'h0);
      cmp("x9_no_err", {31'b0, sb_err}, 32'h0); tick();

      // overflow on x3
      rs1 = 3;
      for (int i = 0; i < 4; i++) begin drv_issue(3); settle(); tick(); end
      idle(); settle();
      cmp("x3_ovf_err", {31'b0, sb_err}, 32'h1);
      cmp("x3_busy", {31'b0, busy1}, 32'h1); tick();
      rst = 1; settle(); tick();
      rst = 0; settle();
      cmp("x3_rst_err", {31'b0, sb_err}, 32'h0);
      cmp("x3_rst_busy", {31'b0, busy1}, 32'h0); tick();

      // squash with nothing pending, then a plain write
      kill = 1; kill_rd = 4; settle(); tick();
      idle(); settle(); cmp("x4_unf_err", {31'b0, sb_err}, 32'h1); tick();
      rst = 1; settle(); tick();
      idle(); rs2 = 6; drv_wb(6, 32'h0000_0055); settle(); tick();
      idle(); settle();
      cmp("x6_plain_err", {31'b0, sb_err}, 32'h0);
      cmp("x6_plain_data", rdata2, 32'h55); tick();

      // randomised traffic on a small register window
      for (int n = 0; n < 3000; n++) begin
         rst     = ($urandom_range(0, 299) == 0);
         we      = ($urandom_range(0, 2) != 0);
         waddr   = 5'($urandom_range(0, 7));
         wdata   = $urandom;
         issue   = $urandom_range(0, 1);
         rd_we   = ($urandom_range(0, 3) != 0);
         rd      = 5'($urandom_range(0, 7));
         kill    = ($urandom_range(0, 15) == 0);
         kill_rd = 5'($urandom_range(0, 7));
         rs1     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         rs2     = 5'($urandom_range(0, 7));
         settle();
         tick();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
